// File: rtl/time_edit_ctrl.sv
// Time-edit sequencer: snapshots clock/alarm time, edits BCD digits under legal-time limits,
// and commits through a req/ack load handshake. Optional idle auto-abort via EDIT_TIMEOUT_EN.
module time_edit_ctrl #(
    parameter int TIMEOUT_S = 10,
    parameter int ACK_MAX   = 255
) (
    input  logic        CP,
    input  logic        CR,
    input  logic        tick_1hz,
    input  logic        adjust,
    input  logic        mode,
    input  logic        left,
    input  logic        right,
    input  logic        up,
    input  logic        down,
    input  logic        apply,
    input  logic [23:0] cur_time,
    input  logic [15:0] alarm_time,
    input  logic        load_ack,
    output logic [23:0] edit_time,
    output logic [2:0]  cursor,
    output logic        editing,
    output logic        blink,
    output logic        load_counter,
    output logic        load_alarm,
    output logic [23:0] load_data,
    output logic        load_err
);
    localparam int AW = $clog2(ACK_MAX + 1);

    typedef enum logic [1:0] {IDLE, EDIT, COMMIT} state_t;
    state_t state, state_d;

    logic          target;
    logic [5:0]    btn_q;
    logic          adj_e, apply_e, up_e, down_e, left_e, right_e, any_e;
    logic [AW-1:0] ack_cnt;
    logic          ack_expire, timed_out;
    logic [23:0]   time_d;
    logic [2:0]    cursor_d, cur_lo;
    logic [4:0]    bit_lo;
    logic [3:0]    dig, dmax, dnew;

    // Action priority apply > up > down > left > right is resolved here.
    assign adj_e   = adjust & ~btn_q[5];
    assign apply_e = apply  & ~btn_q[4];
    assign up_e    = up     & ~btn_q[3] & ~apply_e;
    assign down_e  = down   & ~btn_q[2] & ~apply_e & ~up_e;
    assign left_e  = left   & ~btn_q[1] & ~apply_e & ~up_e & ~down_e;
    assign right_e = right  & ~btn_q[0] & ~apply_e & ~up_e & ~down_e & ~left_e;
    assign any_e   = apply_e | up_e | down_e | left_e | right_e;

    assign ack_expire = (ack_cnt == AW'(ACK_MAX - 1));
    assign editing    = (state != IDLE);
    assign load_data  = (load_counter | load_alarm) ? edit_time : 24'h0;

`ifdef EDIT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_S + 1);
    logic [TW-1:0] idle_s;

    assign timed_out = tick_1hz & ~any_e & (idle_s == TW'(TIMEOUT_S - 1));

    always_ff @(posedge CP) begin
        if (CR)
            idle_s <= '0;
        else if (state != EDIT || any_e)
            idle_s <= '0;
        else if (tick_1hz)
            idle_s <= idle_s + TW'(1);
    end
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (adj_e) state_d = EDIT;
            EDIT: begin
                if (!adjust || timed_out) state_d = IDLE;
                else if (apply_e)         state_d = COMMIT;
            end
            COMMIT: begin
                if (load_ack)        state_d = IDLE;
                else if (ack_expire) state_d = EDIT;
            end
            default: state_d = IDLE;
        endcase
    end

    // Digit edit / cursor move for the current cycle's single action.
    always_comb begin
        time_d   = edit_time;
        cursor_d = cursor;
        cur_lo   = target ? 3'd2 : 3'd0;
        bit_lo   = {cursor, 2'b00};
        dig      = edit_time[bit_lo +: 4];
        case (cursor)
            3'd1, 3'd3: dmax = 4'd5;
            3'd4:       dmax = (edit_time[23:20] == 4'd2) ? 4'd3 : 4'd9;
            3'd5:       dmax = 4'd2;
            default:    dmax = 4'd9;
        endcase
        dnew = dig;
        if (up_e)
            dnew = (dig >= dmax) ? 4'd0 : dig + 4'd1;
        else if (down_e)
            dnew = (dig == 4'd0) ? dmax : dig - 4'd1;
        if (up_e || down_e) begin
            time_d[bit_lo +: 4] = dnew;
            if (cursor == 3'd5 && dnew == 4'd2 && time_d[19:16] > 4'd3)
                time_d[19:16] = 4'd3;
        end else if (left_e) begin
            cursor_d = (cursor == 3'd5) ? cur_lo : cursor + 3'd1;
        end else if (right_e) begin
            cursor_d = (cursor == cur_lo) ? 3'd5 : cursor - 3'd1;
        end
        if (target)
            time_d[7:0] = 8'h00;
    end

    always_ff @(posedge CP) begin
        if (CR) begin
            state        <= IDLE;
            target       <= 1'b0;
            btn_q        <= '0;
            edit_time    <= '0;
            cursor       <= '0;
            blink        <= 1'b0;
            load_counter <= 1'b0;
            load_alarm   <= 1'b0;
            load_err     <= 1'b0;
            ack_cnt      <= '0;
        end else begin
            state    <= state_d;
            btn_q    <= {adjust, apply, up, down, left, right};
            load_err <= (state == COMMIT) && (state_d == EDIT);

            if (state == IDLE && state_d == EDIT) begin
                target    <= mode;
                edit_time <= mode ? {alarm_time, 8'h00} : cur_time;
                cursor    <= mode ? 3'd2 : 3'd0;
            end else if (state == EDIT && state_d == EDIT) begin
                edit_time <= time_d;
                cursor    <= cursor_d;
            end

            if (state == EDIT && state_d == EDIT)
                blink <= tick_1hz ? ~blink : blink;
            else
                blink <= 1'b0;

            // Request rises with COMMIT entry and is held until ack or expiry.
            if (state != COMMIT && state_d == COMMIT) begin
                load_counter <= ~target;
                load_alarm   <= target;
                ack_cnt      <= '0;
            end else if (state == COMMIT && state_d != COMMIT) begin
                load_counter <= 1'b0;
                load_alarm   <= 1'b0;
            end else if (state == COMMIT) begin
                ack_cnt <= ack_cnt + AW'(1);
            end
        end
    end
endmodule
